sync_down_counter: RTL and testbench

//   Loadable synchronous down counter built from clear-able T flip-flops; the count-down

---
 rtl/sync_down_counter_pkg.sv | 14 +
 rtl/sync_down_counter_if.sv | 26 ++
 rtl/sync_down_counter_tff_cell.sv | 21 ++
 rtl/sync_down_counter.sv | 78 +++++++
 tb/tb_sync_down_counter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/sync_down_counter_pkg.sv
// Shared definitions for the lab counters: FSM state encoding and default width.
package dsd_counter_pkg;

  localparam int DEFAULT_WIDTH = 3;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_e;

endpackage

// File: rtl/sync_down_counter_if.sv
// Control/status bundle of the loadable down counter.
// load and en are level strobes sampled on every rising clk edge (no valid/ready
// back-pressure): the counter always accepts them; load wins over en on the same edge.
interface sync_down_counter_if
  import dsd_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             borrow;
  logic             state_dbg;

  modport master (
    output load, load_val, en,
    input  Q, busy, borrow, state_dbg
  );

  modport slave (
    input  load, load_val, en,
    output Q, busy, borrow, state_dbg
  );
endinterface

// File: rtl/sync_down_counter_tff_cell.sv
// Single toggle flip-flop with asynchronous active-low clear; one bit of the counter.
module tff_cell (
  input  logic clk,
  input  logic clear,
  input  logic t,
  output logic q
);
  logic q_q;
  logic q_d;

  always_comb begin
    q_d = t ? ~q_q : q_q;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/sync_down_counter.sv
// Loadable down counter built from T flip-flops, with one-shot or auto-reload terminal
// behaviour. Define SYNC_DOWN_CNT_RELOAD_EN to reload from the start value after reaching 0.
module sync_down_counter
  import dsd_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                clear,
  sync_down_counter_if.slave  bus
);
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] reload_q, reload_d;
  state_e           state_q, state_d;
  logic             borrow_q, borrow_d;
  logic             lower_zero;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .clear (clear),
      .t     (t[i]),
      .q     (cnt[i])
    );
  end

  always_comb begin
    t          = '0;
    lower_zero = 1'b1;
    state_d    = state_q;
    reload_d   = reload_q;
    borrow_d   = 1'b0;
    if (bus.load) begin
      // Toggle exactly the bits that differ from the new start value.
      t        = cnt ^ bus.load_val;
      reload_d = bus.load_val;
      state_d  = (bus.load_val != '0) ? RUN : IDLE;
    end else if (state_q == RUN && bus.en) begin
      if (cnt == '0) begin
`ifdef SYNC_DOWN_CNT_RELOAD_EN
        t = cnt ^ reload_q;
`else
        state_d = IDLE;
`endif
      end else begin
        // Bit i toggles when every lower bit is already 0.
        for (int i = 0; i < WIDTH; i++) begin
          t[i]       = lower_zero;
          lower_zero = lower_zero & ~cnt[i];
        end
        if (cnt == WIDTH'(1)) begin
          borrow_d = 1'b1;
`ifndef SYNC_DOWN_CNT_RELOAD_EN
          state_d  = IDLE;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q  <= IDLE;
      reload_q <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.Q         = cnt;
  assign bus.busy      = (state_q == RUN);
  assign bus.borrow    = borrow_q;
  assign bus.state_dbg = logic'(state_q);
endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter (one-shot and SYNC_DOWN_CNT_RELOAD_EN builds).
module tb_sync_down_counter;
  localparam int W  = 3;
  localparam int OW = W + 2;

  logic clk;
  logic clear;

  sync_down_counter_if #(.WIDTH(W)) bus ();

  sync_down_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and counters
  logic [OW-1:0] exp_q[$];
  int            n_vec;
  int            n_err;

  // reference model state
  logic [W-1:0] m_q;
  logic [W-1:0] m_reload;
  logic         m_run;
  logic         m_borrow;

  task automatic check_eq(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got busy=%0b borrow=%0b Q=%0d, want busy=%0b borrow=%0b Q=%0d",
               tag, obs[OW-1], obs[OW-2], obs[W-1:0], exp[OW-1], exp[OW-2], exp[W-1:0]);
    end
  endtask

  task automatic model_reset();
    m_q      = '0;
    m_reload = '0;
    m_run    = 1'b0;
    m_borrow = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [W-1:0] v, input logic e);
    m_borrow = 1'b0;
    if (ld) begin
      m_q      = v;
      m_reload = v;
      m_run    = (v != 0);
    end else if (m_run && e) begin
      if (m_q == 0) begin
`ifdef SYNC_DOWN_CNT_RELOAD_EN
        m_q = m_reload;
`else
        m_run = 1'b0;
`endif
      end else begin
        m_q = m_q - 1'b1;
        if (m_q == 0) begin
          m_borrow = 1'b1;
`ifndef SYNC_DOWN_CNT_RELOAD_EN
          m_run    = 1'b0;
`endif
        end
      end
    end
  endtask

  // driver: apply one edge of stimulus, predict, then compare after the edge
  task automatic step(input string tag, input logic ld, input logic [W-1:0] v, input logic e);
    logic [OW-1:0] obs;
    logic [OW-1:0] exp;
    @(negedge clk);
    bus.load     = ld;
    bus.load_val = v;
    bus.en       = e;
    model_edge(ld, v, e);
    exp_q.push_back({m_run, m_borrow, m_q});
    @(posedge clk);
    #1;
    obs = {bus.busy, bus.borrow, bus.Q};
    exp = exp_q.pop_front();
    check_eq(tag, obs, exp);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    clear        = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b0;
    model_reset();

    #12;
    check_eq("reset_state", {bus.busy, bus.borrow, bus.Q}, '0);
    @(negedge clk);
    clear = 1'b1;

    // reset mid-count aborts without waiting for a clock edge
    step("rst_load5", 1'b1, 3'd5, 1'b0);
    step("rst_dec", 1'b0, 3'd0, 1'b1);
    step("rst_dec", 1'b0, 3'd0, 1'b1);
    #2;
    clear = 1'b0;
    #1;
    check_eq("async_clear", {bus.busy, bus.borrow, bus.Q}, '0);
    model_reset();
    @(negedge clk);
    clear = 1'b1;

    // one-shot run from 5, then extra enabled edges
    step("run_load5", 1'b1, 3'd5, 1'b1);
    for (int i = 0; i < 9; i++) step("run_dec", 1'b0, 3'd0, 1'b1);

    // enable gating
    step("gate_load3", 1'b1, 3'd3, 1'b0);
    for (int i = 0; i < 5; i++) step("gate_en", 1'b0, 3'd0, (i % 2) == 0);

    // load beats en on the same edge
    step("prio_load5", 1'b1, 3'd5, 1'b0);
    step("prio_dec", 1'b0, 3'd0, 1'b1);
    step("prio_load6", 1'b1, 3'd6, 1'b1);
    step("prio_after", 1'b0, 3'd0, 1'b1);

    // zero load stays idle
    step("zero_load", 1'b1, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) step("zero_en", 1'b0, 3'd0, 1'b1);

    // full-scale start value
    step("max_load", 1'b1, 3'd7, 1'b1);
    for (int i = 0; i < 9; i++) step("max_dec", 1'b0, 3'd0, 1'b1);

`ifdef SYNC_DOWN_CNT_RELOAD_EN
    step("reload_load2", 1'b1, 3'd2, 1'b1);
    for (int i = 0; i < 7; i++) step("reload_run", 1'b0, 3'd0, 1'b1);
`endif

    // random stimulus
    for (int i = 0; i < 300; i++) begin
      step("rand", $urandom_range(0, 7) == 0, W'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0);
    end

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d leftover entries, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
